// File: rtl/x_div_iter_pkg.sv
// x_div_iter_pkg: shared definitions for the iterative signed divider.
// Contents: controller state encoding, iteration count, counter width and
// the most-negative 32-bit value used for the boundary-divisor handling.
package x_div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 5;
    localparam logic [31:0] MIN_INT   = 32'h8000_0000;

endpackage

// File: rtl/x_div_negate.sv
// x_div_negate: 32-bit two's complement negation (combinational).
// Ports:
//   in_val  - value to negate
//   out_val - -in_val (0x80000000 maps to itself)
module x_div_negate (
    input  logic [31:0] in_val,
    output logic [31:0] out_val
);

    assign out_val = ~in_val + 32'd1;

endmodule

// File: rtl/x_div_partial.sv
// x_div_partial: one restoring-division step (combinational).
// Ports:
//   divisor     - divisor magnitude, must be < 2^31
//   partial_in  - {remainder, quotient} already shifted left by one
//   partial_out - updated {remainder, quotient}
module x_div_partial (
    input  logic [31:0] divisor,
    input  logic [63:0] partial_in,
    output logic [63:0] partial_out
);

    logic [31:0] diff;

    assign diff = partial_in[63:32] - divisor;

    // With divisor < 2^31 and remainder < 2*divisor, bit 31 of the
    // difference is an exact "remainder < divisor" indicator.
    always_comb begin
        partial_out = partial_in;
        if (!diff[31]) begin
            partial_out = {diff, partial_in[31:1], 1'b1};
        end
    end

endmodule

// File: rtl/x_div_iter.sv
// x_div_iter: sequential signed 32-bit divider, one restoring step per clock.
// Ports:
//   clock          - rising-edge clock
//   reset_n        - asynchronous active-low reset
//   ctrl_div       - start pulse; also aborts and restarts a running divide
//   data_operandA  - dividend (two's complement)
//   data_operandB  - divisor (two's complement)
//   data_result    - quotient, truncated toward zero
//   data_exception - divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY - one-cycle result-valid pulse, 33 edges after start
//   data_remainder - remainder, sign follows dividend (X_DIV_REMAINDER_EN only)
// Optional feature macro: X_DIV_REMAINDER_EN.
module x_div_iter
    import x_div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = DIV_STEPS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
`ifdef X_DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_resultRDY
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [63:0]        partial_q, partial_d;
    logic [31:0]        divisor_q, divisor_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic               b_min_q, b_min_d;
    logic               a_min_q, a_min_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [31:0] neg_a, neg_b, neg_q, quot_final;
    logic [63:0] step_out;

    x_div_negate u_neg_a (.in_val(data_operandA), .out_val(neg_a));
    x_div_negate u_neg_b (.in_val(data_operandB), .out_val(neg_b));
    x_div_negate u_neg_q (.in_val(partial_q[31:0]), .out_val(neg_q));

    x_div_partial u_step (
        .divisor    (divisor_q),
        .partial_in ({partial_q[62:0], 1'b0}),
        .partial_out(step_out)
    );

    // Divisor 0x80000000 bypasses the step result: |A| <= 2^31 gives q in {0,1}.
    always_comb begin
        quot_final = sign_a_q ^ sign_b_q ? neg_q : partial_q[31:0];
        if (b_zero_q) begin
            quot_final = '0;
        end else if (b_min_q) begin
            quot_final = a_min_q ? 32'd1 : 32'd0;
        end
    end

`ifdef X_DIV_REMAINDER_EN
    logic [31:0] neg_r, rem_final;
    logic [31:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    x_div_negate u_neg_r (.in_val(partial_q[63:32]), .out_val(neg_r));

    always_comb begin
        rem_final = sign_a_q ? neg_r : partial_q[63:32];
        if (b_zero_q) begin
            rem_final = '0;
        end else if (b_min_q) begin
            rem_final = a_min_q ? 32'd0 : dividend_q;
        end
    end

    always_comb begin
        dividend_d = dividend_q;
        rem_d      = rem_q;
        if (ctrl_div) begin
            dividend_d = data_operandA;
        end else if (state_q == DONE) begin
            rem_d = rem_final;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dividend_q <= '0;
            rem_q      <= '0;
        end else begin
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
        end
    end

    assign data_remainder = rem_q;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        partial_d = partial_q;
        divisor_d = divisor_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        b_min_d   = b_min_q;
        a_min_d   = a_min_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;

        if (ctrl_div) begin
            // A start in any state reloads and restarts; an aborted
            // operation never reaches DONE, so it produces no pulse.
            sign_a_d  = data_operandA[31];
            sign_b_d  = data_operandB[31];
            b_zero_d  = (data_operandB == '0);
            b_min_d   = (data_operandB == MIN_INT);
            a_min_d   = (data_operandA == MIN_INT);
            partial_d = {32'b0, data_operandA[31] ? neg_a : data_operandA};
            divisor_d = data_operandB[31] ? neg_b : data_operandB;
            count_d   = '0;
            state_d   = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    partial_d = step_out;
                    count_d   = count_q + 1'b1;
                    if (count_q == CNT_W'(STEPS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    result_d = quot_final;
                    exc_d    = b_zero_q;
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            partial_q <= '0;
            divisor_q <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            b_min_q   <= 1'b0;
            a_min_q   <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            partial_q <= partial_d;
            divisor_q <= divisor_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            b_min_q   <= b_min_d;
            a_min_q   <= a_min_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_x_div_iter.sv
// tb_x_div_iter: self-checking bench for x_div_iter (directed + random).
module tb_x_div_iter;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef X_DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int checks = 0;
    int errors = 0;

    x_div_iter #(.WIDTH(32), .STEPS(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_div      (ctrl_div),
        .data_operandA (a_in),
        .data_operandB (b_in),
        .data_result   (data_result),
        .data_exception(data_exception),
`ifdef X_DIV_REMAINDER_EN
        .data_remainder(data_remainder),
`endif
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    // Reference: signed division truncating toward zero, special cases explicit.
    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return 32'd0;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return 32'(sa / sb);
    endfunction

    function automatic logic [31:0] ref_rem(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return 32'd0;
        if (b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        a_in = a;
        b_in = b;
        ctrl_div = 1'b1;
        @(posedge clock);
        #1 ctrl_div = 1'b0;
    endtask

    // Edge index (after start) at which RDY is first seen, -1 if never within 40.
    task automatic wait_rdy(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic expect_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int edges;
        logic [31:0] q;
        q = ref_quot(a, b);
        start(a, b);
        wait_rdy(edges);
        check({tag, " latency"}, 32'(edges), 32'd33);
        check({tag, " result"}, data_result, q);
        check({tag, " exception"}, {31'b0, data_exception}, {31'b0, b == 32'd0});
`ifdef X_DIV_REMAINDER_EN
        check({tag, " remainder"}, data_remainder, ref_rem(a, b));
`endif
        @(posedge clock);
        #1;
        check({tag, " rdy_pulse_width"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, " result_hold"}, data_result, q);
    endtask

    initial begin
        int edges;
        int rdy_seen;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'b0, data_exception}, 32'd0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        expect_op("pos_pos", 32'd100, 32'd7);
        expect_op("neg_pos", -32'sd100, 32'd7);
        expect_op("pos_neg", 32'd100, -32'sd7);
        expect_op("div_zero", 32'd5, 32'd0);
        expect_op("min_min", MIN_INT, MIN_INT);
        expect_op("min_m1", MIN_INT, 32'hFFFF_FFFF);
        expect_op("seven_min", 32'd7, MIN_INT);
        expect_op("neg_min_rem", -32'sd9, MIN_INT);
        expect_op("zero_div", 32'd0, 32'd13);
        expect_op("max_one", 32'h7FFF_FFFF, 32'd1);

        // Restart mid-operation at count=10
        start(32'd100, 32'd7);
        repeat (10) @(posedge clock);
        start(32'd9, 32'd3);
        wait_rdy(edges);
        check("restart latency", 32'(edges), 32'd33);
        check("restart result", data_result, 32'd3);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("restart single_rdy", 32'(rdy_seen), 32'd0);

        // Reset mid-operation at count=20
        start(32'd100, 32'd7);
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset result", data_result, 32'd0);
        check("midreset exception", {31'b0, data_exception}, 32'd0);
        check("midreset rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("midreset no_rdy", 32'(rdy_seen), 32'd0);
        expect_op("after_reset", -32'sd1000, -32'sd33);

        // Random operands, mixing full-range and small divisors
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 3 == 1) rb = 32'($urandom_range(1, 300));
            if (n % 3 == 2) rb = -32'($urandom_range(1, 300));
            if (n % 8 == 5) ra = MIN_INT;
            expect_op("random", ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
